// File: rtl/freq_div_ctrl_if.sv
// Config port bundle for the tick scheduler: host-side word plus accept/reject status.
// Latency: n/a (signal container only).
// Backpressure: CfgReady low holds the word at the master until the slave can take it.
interface freq_div_ctrl_if #(
  parameter int CNT_W   = 21,
  parameter int BURST_W = 16
);
  logic               CfgValid;
  logic               CfgReady;
  logic [CNT_W-1:0]   CfgDiv;
  logic [BURST_W-1:0] CfgBurst;
  logic               CfgErr;

  modport master (
    output CfgValid,
    output CfgDiv,
    output CfgBurst,
    input  CfgReady,
    input  CfgErr
  );

  modport slave (
    input  CfgValid,
    input  CfgDiv,
    input  CfgBurst,
    output CfgReady,
    output CfgErr
  );
endinterface

// File: rtl/freq_div_ctrl.sv
// Programmable tick scheduler: divides Clk by a loaded ratio, bounded or free-running bursts.
// Latency: first Tick registered DivReg edges after the Start edge; Tick/Done/CfgErr are registered pulses.
// Backpressure: CfgReady drops while running; a config word offered in RUN waits until the run ends.
module freq_div_ctrl #(
  parameter int CNT_W   = 21,
  parameter int BURST_W = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  freq_div_ctrl_if.slave     cfg,
  input  logic               Start,
  input  logic               Stop,
  output logic               Tick,
  output logic               Done,
  output logic               Busy,
  output logic [BURST_W-1:0] TickCnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   DIV_ONE   = 1;
  localparam logic [BURST_W-1:0] BURST_ONE = 1;

  state_t             state;
  logic [CNT_W-1:0]   div_reg;
  logic [CNT_W-1:0]   counter;
  logic [BURST_W-1:0] burst_reg;
  logic [BURST_W-1:0] tick_cnt;
  logic               tick_r;
  logic               done_r;
  logic               err_r;
  logic               busy_r;

  logic               cfg_ready;
  logic               cfg_fire;
  logic               div_ok;
  logic               period_end;
  logic [BURST_W-1:0] tick_cnt_nxt;
  logic               last_tick;

  // Ready is a pure decode of state, forced low while reset is held.
  assign cfg_ready    = Rst & (state != RUN);
  assign cfg_fire     = cfg.CfgValid & cfg_ready;
  assign div_ok       = (cfg.CfgDiv != '0);

  // Full-width compare; div_reg is never zero once RUN is reachable.
  assign period_end   = (counter == (div_reg - DIV_ONE));
  assign tick_cnt_nxt = tick_cnt + BURST_ONE;
  // Terminal edge of a bounded burst: outranks Stop so the last Tick/Done still go out.
  assign last_tick    = period_end && (burst_reg != '0) && (tick_cnt_nxt == burst_reg);

  // Control FSM with registered Tick/Done/CfgErr pulses and Busy.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      div_reg   <= '0;
      burst_reg <= '0;
      counter   <= '0;
      tick_cnt  <= '0;
      tick_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE, LOADED: begin
          if (cfg_fire) begin
            // A handshake on this edge swallows any Start.
            if (div_ok) begin
              div_reg   <= cfg.CfgDiv;
              burst_reg <= cfg.CfgBurst;
              state     <= LOADED;
            end else begin
              err_r <= 1'b1;
            end
          end else if ((state == LOADED) && Start && !Stop) begin
            state    <= RUN;
            busy_r   <= 1'b1;
            counter  <= '0;
            tick_cnt <= '0;
          end
        end
        RUN: begin
          if (last_tick) begin
            counter  <= '0;
            tick_r   <= 1'b1;
            done_r   <= 1'b1;
            tick_cnt <= tick_cnt_nxt;
            state    <= LOADED;
            busy_r   <= 1'b0;
          end else if (Stop) begin
            counter <= '0;
            state   <= LOADED;
            busy_r  <= 1'b0;
          end else if (period_end) begin
            counter  <= '0;
            tick_r   <= 1'b1;
            tick_cnt <= tick_cnt_nxt;
          end else begin
            counter <= counter + DIV_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.CfgReady = cfg_ready;
  assign cfg.CfgErr   = err_r;
  assign Tick         = tick_r;
  assign Done         = done_r;
  assign Busy         = busy_r;
  assign TickCnt      = tick_cnt;

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
Programmable tick scheduler that sequences a free-running divider counter for downstream blocks (LED blinkers, RAM init pacing, sample strobes). A host loads a divide ratio and tick budget through a valid/ready config port, then starts and stops the divider. The block emits single-cycle Tick enables and signals burst completion. It replaces fixed-size dividers wherever software-selectable rates or bounded tick bursts are needed.

Parameters:
CNT_W, 21, width of divide ratio and internal counter
BURST_W, 16, width of tick budget and tick counter

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset (0 = reset asserted)
CfgValid  in  1  config word valid
CfgReady  out  1  config accepted this cycle when CfgValid & CfgReady
CfgDiv  in  CNT_W  divide ratio, Tick period in Clk cycles; 0 is illegal
CfgBurst  in  BURST_W  ticks per run; 0 = free-run until Stop
CfgErr  out  1  one-cycle pulse: config rejected (CfgDiv == 0)
Start  in  1  level, sampled each edge
Stop  in  1  level, sampled each edge
Tick  out  1  one-cycle enable pulse, period CfgDiv
Done  out  1  one-cycle pulse coincident with final Tick of a bounded burst
Busy  out  1  high while in RUN
TickCnt  out  BURST_W  ticks issued since last Start

Behaviour:
- Clk and Rst are the only clock and reset. Rst is asynchronous and active-low. All flops clear immediately on Rst low.
- Reset values: state IDLE, DivReg=0, BurstReg=0, counter=0, TickCnt=0, Tick=0, Done=0, CfgErr=0, Busy=0. CfgReady=0 while Rst is low.
- States: IDLE (no valid config), LOADED (config held, stopped), RUN.
- CfgReady = 1 in IDLE and LOADED, 0 in RUN. CfgValid in RUN is ignored; the host must hold it.
- Config handshake:
  - CfgValid & CfgReady with CfgDiv != 0: latch DivReg and BurstReg; next state LOADED.
  - CfgDiv == 0: word is consumed but discarded; CfgErr pulses the following cycle; state and registers are unchanged.
- IDLE: Start is ignored.
- LOADED:
  - Start=1 & Stop=0 at edge e0: enter RUN; counter and TickCnt are cleared at e0.
  - Start & Stop together: Stop wins; remain in LOADED.
  - A config handshake and Start on the same edge: the config takes effect and Start is ignored.
- RUN counting, per edge:
  - counter == DivReg-1: counter -> 0, Tick=1, TickCnt+1 (wraps silently at 2^BURST_W in free-run).
  - Otherwise: counter+1, Tick=0.
- RUN timing: first Tick is registered at edge e_DivReg, i.e. the DivReg-th edge after e0. Subsequent Ticks follow every DivReg cycles. DivReg=1 gives Tick high every cycle in RUN.
- Bounded burst (BurstReg != 0): on the edge issuing tick number BurstReg, Tick=1 and Done=1, next state LOADED. TickCnt then holds BurstReg.
- Stop in RUN: next state LOADED; no Tick and no Done on that edge. TickCnt holds; counter is cleared.
- Stop coinciding with a terminal edge: the final Tick and Done still issue; next state LOADED.
- Start while in RUN: ignored (no restart).
- Busy = (state == RUN), registered with the state.
- Re-Start from LOADED reuses the held config with a fresh counter and TickCnt.
- Counter compare is done at full CNT_W width. DivReg-1 is computed only when DivReg != 0, which is guaranteed by the config check.
- Reset asserted mid-RUN: outputs clear asynchronously; after release the block is in IDLE and requires a new config.

Test Plan:
- Reset then config CfgDiv=4, CfgBurst=3, Start pulse at edge e0 -> Tick at e4, e8, e12; Done with Tick at e12; Busy drops after e12; TickCnt=3.
- CfgDiv=1, CfgBurst=0, Start, Stop after 10 cycles -> Tick high each cycle in RUN; TickCnt=10; no Done; state LOADED; CfgReady=1.
- CfgDiv=0 with CfgValid -> CfgErr one-cycle pulse; state stays IDLE; a following Start produces no Tick.
- CfgDiv=5, CfgBurst=2, Stop asserted on the edge of the 2nd Tick -> Tick and Done still issue; state LOADED.
- RUN with CfgValid held high carrying a new CfgDiv=7 -> CfgReady=0 until the burst ends; config accepted on the first LOADED cycle; the next Start yields period 7.
- Rst driven low asynchronously mid-period (between edges) -> Tick, Busy, TickCnt clear without a clock edge; after release CfgReady=1 and state IDLE.
